// File: rtl/rf_pkg.sv
// Shared definitions for the two-write/two-read integer register file.
//  rf_state_e  : sequencer state (RF_INIT clears the array, RF_RUN is normal use)
//  RF_XLEN     : default register width
//  RF_NREGS    : default number of architectural registers
//  RV_ZERO_REG : index of the hardwired-zero register
package rf_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  localparam int RF_XLEN     = 32;
  localparam int RF_NREGS    = 32;
  localparam int RV_ZERO_REG = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register.
// Ports:
//  clk_i, rst_ni           clock, asynchronous active-low clear of all bits
//  set_i / set_addr_i      mark a register pending (load issued)
//  clr_i / clr_addr_i      clear a register's pending bit (load written back)
//  lk_addr1_i, lk_addr2_i  lookup addresses
//  pend1_o, pend2_o        registered pending bit of each lookup address
// Callers gate set_i/clr_i themselves; this block only applies the priority.
module rf_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          set_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic          clr_i,
  input  logic [AW-1:0] clr_addr_i,
  input  logic [AW-1:0] lk_addr1_i,
  input  logic [AW-1:0] lk_addr2_i,
  output logic          pend1_o,
  output logic          pend2_o
);

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  // Set is applied after clear so a new load issued to a register that is
  // being written back in the same cycle keeps it pending.
  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d[clr_addr_i] = 1'b0;
    if (set_i) pend_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend1_o = pend_q[lk_addr1_i];
  assign pend2_o = pend_q[lk_addr2_i];

endmodule

// File: rtl/regfile_2w2r_sb.sv
// Integer register file: 2 combinational read ports, 2 clocked write ports
// (port 0 = ALU writeback, port 1 = load writeback), optional write->read
// bypass, per-register pending-load scoreboard and a post-reset clear
// sequencer.
// Ports:
//  clk, rst_n                      clock, asynchronous active-low reset
//  rd_addr1/2 -> rd_data1/2        combinational reads (x0 reads 0)
//  wr_en0/wr_addr0/wr_data0        ALU write port
//  wr_en1/wr_addr1/wr_data1        load write port (wins on address clash,
//                                  also clears the pending bit)
//  busy_set/busy_addr              mark a register pending
//  busy1/busy2                     rd_addr1/2 has an outstanding load
//  init_done                       array clear finished, file usable
//  dbg_state                       current sequencer state
// No handshakes: every input is sampled unconditionally each cycle, and
// writes/busy_set are silently dropped while init_done is low.
module regfile_2w2r_sb
  import rf_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREGS  = RF_NREGS,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  input  logic            wr_en0,
  input  logic [AW-1:0]   wr_addr0,
  input  logic [XLEN-1:0] wr_data0,
  input  logic            wr_en1,
  input  logic [AW-1:0]   wr_addr1,
  input  logic [XLEN-1:0] wr_data1,
  input  logic            busy_set,
  input  logic [AW-1:0]   busy_addr,
  output logic            busy1,
  output logic            busy2,
  output logic            init_done,
  output rf_state_e       dbg_state
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(RV_ZERO_REG);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);
  localparam bit            BYP_ON    = (BYPASS != 0);

  rf_state_e       state_q;
  rf_state_e       state_d;
  logic [AW-1:0]   clr_cnt_q;
  logic [AW-1:0]   clr_cnt_d;
  logic [XLEN-1:0] mem_q [NREGS];

  logic run;
  logic we0;
  logic we1;
  logic sb_set;
  logic pend1;
  logic pend2;

  assign run = (state_q == RF_RUN);
  // Effective write enables: only in RUN, and never to the zero register.
  assign we0    = run && wr_en0   && (wr_addr0  != ZERO_ADDR);
  assign we1    = run && wr_en1   && (wr_addr1  != ZERO_ADDR);
  assign sb_set = run && busy_set && (busy_addr != ZERO_ADDR);

  // Clear sequencer: entry 0 is never stored, so counting starts at 1 and
  // the last entry is written on the edge that moves to RUN.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      RF_INIT: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = RF_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      RF_RUN:  state_d = RF_RUN;
      default: state_d = RF_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RF_INIT;
      clr_cnt_q <= AW'(1);
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Array has no reset; the sequencer zeroes it. Port 1 is written last so
  // it wins when both ports target the same register.
  always_ff @(posedge clk) begin
    if (state_q == RF_INIT) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      if (we0) mem_q[wr_addr0] <= wr_data0;
      if (we1) mem_q[wr_addr1] <= wr_data1;
    end
  end

  always_comb begin
    rd_data1 = '0;
    if (run && (rd_addr1 != ZERO_ADDR)) begin
      rd_data1 = mem_q[rd_addr1];
      if (BYP_ON) begin
        if (we1 && (wr_addr1 == rd_addr1))      rd_data1 = wr_data1;
        else if (we0 && (wr_addr0 == rd_addr1)) rd_data1 = wr_data0;
      end
    end
  end

  always_comb begin
    rd_data2 = '0;
    if (run && (rd_addr2 != ZERO_ADDR)) begin
      rd_data2 = mem_q[rd_addr2];
      if (BYP_ON) begin
        if (we1 && (wr_addr1 == rd_addr2))      rd_data2 = wr_data1;
        else if (we0 && (wr_addr0 == rd_addr2)) rd_data2 = wr_data0;
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .set_i      (sb_set),
    .set_addr_i (busy_addr),
    .clr_i      (we1),
    .clr_addr_i (wr_addr1),
    .lk_addr1_i (rd_addr1),
    .lk_addr2_i (rd_addr2),
    .pend1_o    (pend1),
    .pend2_o    (pend2)
  );

  // With bypass the load data is already visible, so a register being
  // written back this cycle is no longer reported busy.
  assign busy1 = run && (rd_addr1 != ZERO_ADDR) && pend1 &&
                 !(BYP_ON && we1 && (wr_addr1 == rd_addr1));
  assign busy2 = run && (rd_addr2 != ZERO_ADDR) && pend2 &&
                 !(BYP_ON && we1 && (wr_addr1 == rd_addr2));

  assign init_done = run;
  assign dbg_state = state_q;

endmodule
